// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg -- shared constants and types for the tick_gen divider block.
//
// Contents:
//   NUM_CH_DEF   default number of divider channels
//   CNT_W_DEF    counter / half-period width in bits (fixes ch_state_t)
//   DEF_HALF_DEF half-period loaded on reset, in clk_in cycles
//   CFG_CH_W     width of the channel-select field on the config port
//   ch_state_t   per-channel state: running counter, active and pending
//                half-periods
//   eff_m1()     terminal-count value for a given active half-period
//
// Optional feature macro used by the block: TICK_GEN_TICK_OUT_EN
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int NUM_CH_DEF   = 3;
    localparam int CNT_W_DEF    = 24;
    localparam int DEF_HALF_DEF = 50;
    localparam int CFG_CH_W     = 3;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] cnt;   // cycles elapsed in the current phase
        logic [CNT_W_DEF-1:0] act;   // half-period governing the current phase
        logic [CNT_W_DEF-1:0] pend;  // half-period waiting for the next phase
    } ch_state_t;

    // A half-period of zero is treated as one, so the terminal count is 0 for
    // both act==0 and act==1.
    function automatic logic [CNT_W_DEF-1:0] eff_m1(input logic [CNT_W_DEF-1:0] act);
        return (act == '0) ? '0 : act - 1'b1;
    endfunction

endpackage : tick_gen_pkg

// File: rtl/tick_gen_if.sv
// -----------------------------------------------------------------------------
// tick_gen_if -- half-period configuration port of tick_gen.
//
// Signals:
//   cfg_we    write strobe, one clk_in cycle per write
//   cfg_ch    target channel; values >= NUM_CH are dropped by the block
//   cfg_half  new half-period in clk_in cycles
//
// Handshake: cfg_we is a valid-only strobe with no ready. A write is accepted
// in every cycle where cfg_we is sampled high (even during sync_clr); there is
// no backpressure and nothing is held, so the master may present a new write
// on every cycle.
//
// Modports: master drives the port, slave (the tick_gen block) samples it.
// -----------------------------------------------------------------------------
interface tick_gen_if #(
    parameter int CNT_W = tick_gen_pkg::CNT_W_DEF
);
    logic                               cfg_we;
    logic [tick_gen_pkg::CFG_CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0]                   cfg_half;

    modport master (output cfg_we, output cfg_ch, output cfg_half);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_half);
endinterface : tick_gen_if

// File: rtl/tick_gen_ch.sv
// -----------------------------------------------------------------------------
// tick_gen_ch -- one square-wave divider channel of tick_gen.
//
// Ports:
//   clk_in    clock, all state on the rising edge
//   rst       synchronous active-high reset
//   en        run enable for this channel
//   sync_clr  restart this channel at phase zero with the output low
//   wr        write strobe for this channel's pending half-period
//   wr_half   value written into the pending half-period
//   clk_out   registered square wave, period 2*eff cycles
//   tick      registered one-cycle pulse on each clk_out rise
//             (present only with TICK_GEN_TICK_OUT_EN defined)
//
// A new half-period is staged in pend and only promoted to act at a terminal
// count (or while the channel is disabled), so a running phase is never cut
// short by a configuration write.
// -----------------------------------------------------------------------------
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync_clr,
    input  logic                 wr,
    input  logic [CNT_W_DEF-1:0] wr_half,
    output logic                 clk_out
`ifdef TICK_GEN_TICK_OUT_EN
    ,
    output logic                 tick
`endif
);

    localparam logic [CNT_W_DEF-1:0] RST_HALF = CNT_W_DEF'(DEF_HALF);

    ch_state_t st;
    logic      tc;

    // Terminal count: the last cycle of the current phase. Never asserted
    // while sync_clr or a disabled channel is forcing the restart.
    assign tc = en && !sync_clr && (st.cnt == eff_m1(st.act));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            st.cnt  <= '0;
            st.act  <= RST_HALF;
            st.pend <= RST_HALF;
            clk_out <= 1'b0;
        end else begin
            // The config write lands in pend regardless of what the counter
            // does this cycle; a coincident TC still promotes the old pend.
            if (wr) begin
                st.pend <= wr_half;
            end

            if (sync_clr) begin
                st.cnt  <= '0;
                clk_out <= 1'b0;
            end else if (!en) begin
                st.cnt  <= '0;
                st.act  <= st.pend;
                clk_out <= 1'b0;
            end else if (tc) begin
                st.cnt  <= '0;
                st.act  <= st.pend;
                clk_out <= ~clk_out;
            end else begin
                st.cnt  <= st.cnt + 1'b1;
            end
        end
    end

`ifdef TICK_GEN_TICK_OUT_EN
    // A TC with the output currently low is exactly the 0->1 transition.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= tc && !clk_out;
        end
    end
`endif

endmodule : tick_gen_ch

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen -- bank of independent programmable clock dividers.
//
// Ports:
//   clk_in    sole clock, rising edge
//   rst       synchronous active-high reset (highest priority)
//   en        per-channel run enable, NUM_CH bits
//   sync_clr  restarts every channel phase-aligned with outputs low
//   cfg       tick_gen_if.slave: cfg_we / cfg_ch / cfg_half write port
//   clk_out   per-channel registered square wave, NUM_CH bits
//   tick      per-channel one-cycle pulse on clk_out rise, NUM_CH bits
//             (present only with TICK_GEN_TICK_OUT_EN defined)
//
// Parameters: NUM_CH (1..8) channels, DEF_HALF reset half-period. The counter
// width is the package CNT_W_DEF, since it sizes the channel state type.
//
// Optional feature macro: TICK_GEN_TICK_OUT_EN adds the tick output.
// -----------------------------------------------------------------------------
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    tick_gen_if.slave         cfg,
    output logic [NUM_CH-1:0] clk_out
`ifdef TICK_GEN_TICK_OUT_EN
    ,
    output logic [NUM_CH-1:0] tick
`endif
);

    logic [NUM_CH-1:0] wr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Only channel numbers that exist can match, so writes addressed to
        // cfg_ch >= NUM_CH fall through with no effect.
        assign wr[c] = cfg.cfg_we && (cfg.cfg_ch == CFG_CH_W'(c));

        tick_gen_ch #(
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (en[c]),
            .sync_clr (sync_clr),
            .wr       (wr[c]),
            .wr_half  (cfg.cfg_half),
            .clk_out  (clk_out[c])
`ifdef TICK_GEN_TICK_OUT_EN
            ,
            .tick     (tick[c])
`endif
        );
    end

endmodule : tick_gen

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 NUM_CH, 3, number of independent divider channels (1..8).
REQ-002 CNT_W, 24, counter and half-period width in bits.
REQ-003 DEF_HALF, 50, reset half-period in clk_in cycles, common to all channels.
REQ-004 clk_in  input  1  sole clock, all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  NUM_CH  per-channel run enable.
REQ-007 sync_clr  input  1  restarts all channels phase-aligned.
REQ-008 cfg_we  input  1  write strobe for the half-period.
REQ-009 cfg_ch  input  3  target channel of the write.
REQ-010 cfg_half  input  CNT_W  new half-period value.
REQ-011 clk_out  output  NUM_CH  per-channel square wave, registered.
REQ-012 tick  output  NUM_CH  per-channel single-cycle pulse, registered, only under TICK_OUT_EN.

Function
REQ-013 Each channel SHALL hold a counter cnt, an active half-period act and a pending half-period pend.
REQ-014 Effective half-period eff SHALL be act, with act==0 treated as 1.
REQ-015 While en[c]=1, cnt SHALL increment each cycle; when cnt==eff-1, cnt SHALL go to 0 and clk_out[c] SHALL toggle (terminal count, TC).
REQ-016 Output period SHALL be 2*eff cycles at 50% duty; eff=1 gives clk_in/2.
REQ-017 cfg_we with cfg_ch<NUM_CH SHALL write cfg_half into pend of that channel; cfg_ch>=NUM_CH SHALL be ignored.
REQ-018 pend SHALL be copied into act at the next TC only, so no output high or low phase is ever truncated.
REQ-019 A write in the same cycle as a TC SHALL land in pend and take effect at the following TC; the TC in progress uses the old act.
REQ-020 While en[c]=0: cnt=0, clk_out[c]=0, tick[c]=0, and act<=pend every cycle.
REQ-021 On an en[c] 0->1 transition, the first toggle SHALL occur eff cycles after the first cycle with en high.
REQ-022 sync_clr=1 SHALL set cnt=0 and clk_out=0 on all channels; pend and act are untouched.
REQ-023 Priority SHALL be rst > sync_clr > en; a cfg write coinciding with sync_clr SHALL still update pend.
REQ-024 Channels SHALL be fully independent apart from sync_clr and the shared config port.

Reset
REQ-025 rst SHALL set cnt=0, clk_out=0, tick=0, and act=pend=DEF_HALF on every channel.
REQ-026 rst asserted mid-period SHALL abort the period; there is no partial-period carryover after release.
REQ-027 The first toggle after rst release with en high SHALL occur DEF_HALF cycles after release.

Configuration
REQ-028 Macro TICK_GEN_TICK_OUT_EN defined: the tick port exists, and tick[c] pulses for exactly one cycle, coincident with each clk_out[c] 0->1 transition.
REQ-029 Macro undefined: the tick port and its logic are absent; clk_out behaviour is identical.

Structure
REQ-030 Package tick_gen_pkg SHALL hold the defaults for NUM_CH, CNT_W and DEF_HALF, plus the channel-state typedef (cnt, act, pend).
REQ-031 Sub-module tick_gen_ch SHALL implement one channel; tick_gen instantiates NUM_CH copies and decodes cfg_ch.

Verification
REQ-032 rst 1 for 3 cycles, en=3'b111 -> all clk_out stay 0 for 50 cycles, first rise at cycle 50, period 100.
REQ-033 cfg_we, cfg_ch=1, cfg_half=4 mid-period -> ch1 completes its current 50-cycle phase, then runs period 8; ch0 and ch2 unchanged.
REQ-034 cfg_half=0 on ch2 -> ch2 toggles every cycle after the next TC; write with cfg_ch=5 -> no state change.
REQ-035 en[0] dropped for 7 cycles, then re-raised -> clk_out[0]=0 while low, first rise exactly eff cycles after re-raise.
REQ-036 Channels set to half-periods 3, 5 and 7, then sync_clr pulsed -> all outputs rise together 3, 5 and 7 cycles later respectively; sync_clr together with rst -> reset values.
REQ-037 With TICK_GEN_TICK_OUT_EN defined and half-period 2 -> tick high for one cycle every 4 cycles, aligned to clk_out rises.
